// File: rtl/dff_onboth_pkg.sv
// Shared state encoding for the dff_onboth sequencer.
// Kept in a package so neighbouring datapath blocks decode the same values.
package dff_onboth_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t FIRST  = 2'd1;
  localparam state_t REPEAT = 2'd2;
  localparam state_t EXIT   = 2'd3;

  typedef struct packed {
    logic f;
    logic r;
    logic x;
    logic g;
  } seq_out_t;

  function automatic seq_out_t decode_out(
    input state_t cur,
    input state_t nxt
  );
    seq_out_t o;
    o.f = (nxt == FIRST);
    o.r = (nxt == REPEAT);
    o.x = (nxt == EXIT);
    o.g = (nxt != cur);
    return o;
  endfunction

endpackage

// File: rtl/dff_onboth.sv
// FIRST/REPEAT/EXIT sequencer with every output held in a flop,
// loaded from next-state logic so outputs move with the state edge.
module dff_onboth
  import dff_onboth_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic do_req,
  output logic f,
  output logic r,
  output logic x,
  output logic g
);

  state_t   state;
  state_t   state_nxt;
  seq_out_t out_nxt;

  always_comb begin
    state_nxt = IDLE;
    unique case (1'b1)
      (state == IDLE):   state_nxt = do_req ? FIRST : IDLE;
      (state == FIRST):  state_nxt = REPEAT;
      (state == REPEAT): state_nxt = do_req ? REPEAT : EXIT;
      (state == EXIT):   state_nxt = IDLE;
      default:           state_nxt = IDLE;
    endcase
  end

  assign out_nxt = decode_out(state, state_nxt);

  // Reset is synchronous and lands in IDLE without a transition pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      f     <= 1'b0;
      r     <= 1'b0;
      x     <= 1'b0;
      g     <= 1'b0;
    end else begin
      state <= state_nxt;
      f     <= out_nxt.f;
      r     <= out_nxt.r;
      x     <= out_nxt.x;
      g     <= out_nxt.g;
    end
  end

endmodule

// File: tb/tb_dff_onboth.sv
// Scoreboard bench for dff_onboth: driver queues {f,r,x,g}
// expected after each edge, monitor pops and compares on negedge.
module tb_dff_onboth;

  logic clk;
  logic rst_n;
  logic do_req;
  logic f;
  logic r;
  logic x;
  logic g;

  int n_tests;
  int n_failed;

  logic [3:0] exp_q[$];
  string      name_q[$];

  dff_onboth dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .do_req (do_req),
    .f      (f),
    .r      (r),
    .x      (x),
    .g      (g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(
    input logic       d,
    input logic       rn,
    input logic [3:0] exp,
    input string      nm
  );
    do_req = d;
    rst_n  = rn;
    @(posedge clk);
    exp_q.push_back(exp);
    name_q.push_back(nm);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [3:0] e;
      string      nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests++;
      if ({f, r, x, g} !== e) begin
        n_failed++;
        $display("FAIL %s: frxg got %b want %b at t=%0t",
                 nm, {f, r, x, g}, e, $time);
      end
    end
  end

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst_n    = 1'b0;
    do_req   = 1'b0;

    step(0, 0, 4'b0000, "reset0");
    step(0, 0, 4'b0000, "reset1");
    step(0, 1, 4'b0000, "idle0");
    step(0, 1, 4'b0000, "idle1");

    step(1, 1, 4'b1001, "start_first");
    step(1, 1, 4'b0101, "start_repeat");
    step(1, 1, 4'b0100, "start_dwell");
    for (int i = 0; i < 7; i++)
      step(1, 1, 4'b0100, "hold");

    step(0, 1, 4'b0011, "stop_exit");
    step(0, 1, 4'b0001, "stop_idle_g");
    step(0, 1, 4'b0000, "stop_idle");

    step(1, 1, 4'b1001, "pulse_first");
    step(0, 1, 4'b0101, "pulse_repeat");
    step(0, 1, 4'b0011, "pulse_exit");
    step(0, 1, 4'b0001, "pulse_idle_g");
    step(0, 1, 4'b0000, "pulse_idle");

    step(1, 1, 4'b1001, "reent_first");
    step(1, 1, 4'b0101, "reent_repeat");
    step(0, 1, 4'b0011, "reent_exit");
    step(1, 1, 4'b0001, "exit_ignores_do");
    step(1, 1, 4'b1001, "reent_first2");
    step(1, 1, 4'b0101, "reent_repeat2");
    step(1, 1, 4'b0100, "reent_dwell");

    step(1, 0, 4'b0000, "midop_reset");
    step(1, 1, 4'b1001, "post_reset_first");
    step(1, 1, 4'b0101, "post_reset_repeat");
    step(0, 1, 4'b0011, "post_reset_exit");
    step(0, 1, 4'b0001, "post_reset_idle_g");
    step(0, 1, 4'b0000, "post_reset_idle");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_failed++;
      $display("FAIL drain: %0d pending want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
